// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer
// Control FSM for one folded binary convolution layer. Loads per-fold weight
// and threshold words, admits activation pixels over a valid/ready handshake,
// steps fold_add through every output-channel fold per pixel, pulses the
// max-pool shift and tags which layer output words are valid.
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   start, cfg_load                 run request (IDLE only), load config first
//   cfg_valid / cfg_ready           config word handshake
//   act_valid / act_ready           activation pixel handshake
//   stream_act_en                   pixel shift strobe (act handshake)
//   stream_w_en / stream_w_addr     weight write strobe and fold address
//   stream_th_en / stream_th_addr   threshold write strobe and fold address
//   fold_add                        fold currently computed by the PEs
//   stream_maxpool_en               max-pool shift strobe
//   out_valid, out_row, out_col     layer output word valid and coordinates
//   busy, done                      run in progress, end-of-run pulse
module conv_layer_sequencer #(
  parameter int fold           = 2,
  parameter int fold_log       = $clog2(fold),
  parameter int w_in           = 32,
  parameter int h_in           = 32,
  parameter int MAXPOOL_enable = 1,
  parameter int k_s_maxpool    = 2,
  parameter int out_lat        = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                cfg_load,
  input  logic                cfg_valid,
  output logic                cfg_ready,
  input  logic                act_valid,
  output logic                act_ready,
  output logic                stream_act_en,
  output logic                stream_w_en,
  output logic [fold_log-1:0] stream_w_addr,
  output logic                stream_th_en,
  output logic [fold_log-1:0] stream_th_addr,
  output logic [fold_log-1:0] fold_add,
  output logic                stream_maxpool_en,
  output logic                out_valid,
  output logic [15:0]         out_row,
  output logic [15:0]         out_col,
  output logic                busy,
  output logic                done
);

  localparam int unsigned coord_w = 16;
  // Tags only need delaying when the pooling stage sits in the output path.
  localparam int          n_stg   = (MAXPOOL_enable != 0) ? out_lat : 0;

  localparam logic [fold_log-1:0] last_fold = fold_log'(fold - 1);
  localparam logic [coord_w-1:0]  last_col  = coord_w'(w_in - 1);
  localparam logic [coord_w-1:0]  last_row  = coord_w'(h_in - 1);
  localparam logic [coord_w-1:0]  k_pool    = coord_w'(k_s_maxpool);
  localparam logic [coord_w-1:0]  k_last    = coord_w'(k_s_maxpool - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_LOAD_TH,
    S_ACT,
    S_FOLD,
    S_POOL,
    S_DRAIN
  } state_t;

  typedef struct packed {
    logic               valid;
    logic [coord_w-1:0] row;
    logic [coord_w-1:0] col;
  } tag_t;

  state_t              state_q, state_d;
  logic [fold_log-1:0] cnt_q, cnt_d;     // config word index or current fold
  logic [coord_w-1:0]  row_q, row_d;
  logic [coord_w-1:0]  col_q, col_d;
  logic                push_c;
  logic                pipe_busy;
  tag_t                tag_c;
  tag_t                out_tag;

  // State and counter registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      row_q   <= row_d;
      col_q   <= col_d;
    end
  end

  // Next-state, counter updates and state-decoded strobes
  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    row_d             = row_q;
    col_d             = col_q;
    cfg_ready         = 1'b0;
    act_ready         = 1'b0;
    stream_w_en       = 1'b0;
    stream_w_addr     = '0;
    stream_th_en      = 1'b0;
    stream_th_addr    = '0;
    fold_add          = '0;
    stream_maxpool_en = 1'b0;
    push_c            = 1'b0;
    done              = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          cnt_d   = '0;
          row_d   = '0;
          col_d   = '0;
          state_d = cfg_load ? S_LOAD_W : S_ACT;
        end
      end

      S_LOAD_W: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          stream_w_en   = 1'b1;
          stream_w_addr = cnt_q;
          if (cnt_q == last_fold) begin
            cnt_d   = '0;
            state_d = S_LOAD_TH;
          end else begin
            cnt_d = cnt_q + fold_log'(1);
          end
        end
      end

      S_LOAD_TH: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          stream_th_en   = 1'b1;
          stream_th_addr = cnt_q;
          if (cnt_q == last_fold) begin
            cnt_d   = '0;
            state_d = S_ACT;
          end else begin
            cnt_d = cnt_q + fold_log'(1);
          end
        end
      end

      S_ACT: begin
        act_ready = 1'b1;
        if (act_valid) begin
          cnt_d   = '0;
          state_d = S_FOLD;
        end
      end

      S_FOLD: begin
        fold_add = cnt_q;
        if (cnt_q == last_fold) begin
          cnt_d   = '0;
          state_d = S_POOL;
        end else begin
          cnt_d = cnt_q + fold_log'(1);
        end
      end

      S_POOL: begin
        stream_maxpool_en = (MAXPOOL_enable != 0);
        push_c            = 1'b1;
        if (col_q == last_col) begin
          col_d = '0;
          row_d = row_q + coord_w'(1);
        end else begin
          col_d = col_q + coord_w'(1);
        end
        if ((row_q == last_row) && (col_q == last_col)) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_ACT;
        end
      end

      S_DRAIN: begin
        if (!pipe_busy) begin
          done    = 1'b1;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Output tag for the pixel in POOL; a pooled word completes on the
  // bottom-right pixel of each pooling window.
  always_comb begin
    tag_c = '0;
    if (push_c) begin
      if (MAXPOOL_enable != 0) begin
        tag_c.valid = ((row_q % k_pool) == k_last) && ((col_q % k_pool) == k_last);
        if (tag_c.valid) begin
          tag_c.row = row_q / k_pool;
          tag_c.col = col_q / k_pool;
        end
      end else begin
        tag_c.valid = 1'b1;
        tag_c.row   = row_q;
        tag_c.col   = col_q;
      end
    end
  end

  // Tag delay line; occupancy is tracked apart from validity so DRAIN also
  // waits for tags of pixels that produce no output word.
  generate
    if (n_stg > 0) begin : g_dly
      tag_t pipe_q [n_stg];
      logic occ_q  [n_stg];
      logic any_occ_c;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < n_stg; i++) begin
            pipe_q[i] <= '0;
            occ_q[i]  <= 1'b0;
          end
        end else begin
          pipe_q[0] <= tag_c;
          occ_q[0]  <= push_c;
          for (int i = 1; i < n_stg; i++) begin
            pipe_q[i] <= pipe_q[i-1];
            occ_q[i]  <= occ_q[i-1];
          end
        end
      end

      always_comb begin
        any_occ_c = 1'b0;
        for (int i = 0; i < n_stg; i++) begin
          any_occ_c = any_occ_c | occ_q[i];
        end
      end

      assign out_tag   = pipe_q[n_stg-1];
      assign pipe_busy = any_occ_c;
    end else begin : g_bypass
      assign out_tag   = tag_c;
      assign pipe_busy = 1'b0;
    end
  endgenerate

  assign stream_act_en = act_valid & act_ready;
  assign busy          = (state_q != S_IDLE);
  assign out_valid     = out_tag.valid;
  assign out_row       = out_tag.row;
  assign out_col       = out_tag.col;

endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Bench for conv_layer_sequencer: a pooled (index 0) and an unpooled
// (index 1) instance share all inputs. Accepted pixels push expected output
// tags into per-instance queues that are popped on out_valid.
module tb_conv_layer_sequencer;

  localparam int FOLD = 2;
  localparam int FL   = 1;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int K    = 2;
  localparam int LAT  = 2;
  localparam int NPIX = W * H;

  typedef struct {
    int row;
    int col;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset, start, cfg_load, cfg_valid, act_valid;

  logic          cfg_ready [2];
  logic          act_ready [2];
  logic          act_en    [2];
  logic          w_en      [2];
  logic [FL-1:0] w_addr    [2];
  logic          th_en     [2];
  logic [FL-1:0] th_addr   [2];
  logic [FL-1:0] fold_add  [2];
  logic          mp_en     [2];
  logic          out_valid [2];
  logic [15:0]   out_row   [2];
  logic [15:0]   out_col   [2];
  logic          busy      [2];
  logic          done      [2];

  // values sampled at the falling edge
  logic          s_cfg_ready [2];
  logic          s_act_ready [2];
  logic          s_act_en    [2];
  logic          s_w_en      [2];
  logic [FL-1:0] s_w_addr    [2];
  logic          s_th_en     [2];
  logic [FL-1:0] s_th_addr   [2];
  logic [FL-1:0] s_fold      [2];
  logic          s_mp        [2];
  logic          s_ov        [2];
  logic [15:0]   s_row       [2];
  logic [15:0]   s_col       [2];
  logic          s_busy      [2];
  logic          s_done      [2];

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   px       [2];
  int   last_hs  [2];
  int   out_cnt  [2];
  int   done_cnt [2];
  bit   steady;
  exp_t q0 [$];
  exp_t q1 [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  conv_layer_sequencer #(
    .fold(FOLD), .w_in(W), .h_in(H), .MAXPOOL_enable(1), .k_s_maxpool(K), .out_lat(LAT)
  ) u_pool (
    .clk(clk), .reset(reset), .start(start), .cfg_load(cfg_load),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[0]),
    .act_valid(act_valid), .act_ready(act_ready[0]), .stream_act_en(act_en[0]),
    .stream_w_en(w_en[0]), .stream_w_addr(w_addr[0]),
    .stream_th_en(th_en[0]), .stream_th_addr(th_addr[0]),
    .fold_add(fold_add[0]), .stream_maxpool_en(mp_en[0]),
    .out_valid(out_valid[0]), .out_row(out_row[0]), .out_col(out_col[0]),
    .busy(busy[0]), .done(done[0])
  );

  conv_layer_sequencer #(
    .fold(FOLD), .w_in(W), .h_in(H), .MAXPOOL_enable(0), .k_s_maxpool(K), .out_lat(LAT)
  ) u_raw (
    .clk(clk), .reset(reset), .start(start), .cfg_load(cfg_load),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready[1]),
    .act_valid(act_valid), .act_ready(act_ready[1]), .stream_act_en(act_en[1]),
    .stream_w_en(w_en[1]), .stream_w_addr(w_addr[1]),
    .stream_th_en(th_en[1]), .stream_th_addr(th_addr[1]),
    .fold_add(fold_add[1]), .stream_maxpool_en(mp_en[1]),
    .out_valid(out_valid[1]), .out_row(out_row[1]), .out_col(out_col[1]),
    .busy(busy[1]), .done(done[1])
  );

  task automatic chk(input string tag, input int d, input int obs, input int req);
    checks++;
    assert (obs === req) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0d expected=%0d", tag, d, obs, req);
    end
  endtask

  task automatic clear_model();
    q0.delete();
    q1.delete();
    for (int d = 0; d < 2; d++) begin
      px[d]       = 0;
      last_hs[d]  = -1;
      out_cnt[d]  = 0;
      done_cnt[d] = 0;
    end
  endtask

  // Per-cycle model checks for one instance
  task automatic mon(input int d);
    int   exp_f;
    int   exp_m;
    int   r;
    int   c;
    exp_t e;
    exp_f = (last_hs[d] >= 0 && cyc > last_hs[d] && cyc <= last_hs[d] + FOLD) ?
            cyc - last_hs[d] - 1 : 0;
    exp_m = (d == 0 && last_hs[d] >= 0 && cyc == last_hs[d] + FOLD + 1) ? 1 : 0;
    chk("fold_add", d, int'(s_fold[d]), exp_f);
    chk("maxpool_en", d, int'(s_mp[d]), exp_m);

    if (s_act_en[d]) begin
      chk("act_en_qual", d, int'({s_act_ready[d], act_valid}), 3);
      if (last_hs[d] >= 0) begin
        if (steady) chk("act_period", d, cyc - last_hs[d], FOLD + 2);
        else        chk("act_gap_ok", d, int'(cyc - last_hs[d] >= FOLD + 2), 1);
      end
      r = px[d] / W;
      c = px[d] % W;
      if (d == 1) begin
        e = '{r, c, cyc + FOLD + 1};
        q1.push_back(e);
      end else if (r % K == K - 1 && c % K == K - 1) begin
        e = '{r / K, c / K, cyc + FOLD + 1 + LAT};
        q0.push_back(e);
      end
      px[d]++;
      last_hs[d] = cyc;
    end

    if (s_ov[d]) begin
      out_cnt[d]++;
      if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
        chk("spurious_out_valid", d, int'(s_ov[d]), 0);
      end else begin
        e = (d == 0) ? q0.pop_front() : q1.pop_front();
        chk("out_row", d, int'(s_row[d]), e.row);
        chk("out_col", d, int'(s_col[d]), e.col);
        chk("out_cycle", d, cyc, e.cyc);
      end
    end

    if (s_done[d]) begin
      done_cnt[d]++;
      chk("done_cycle", d, cyc, last_hs[d] + ((d == 0) ? FOLD + LAT + 2 : FOLD + 2));
      chk("done_pixels", d, px[d], NPIX);
    end
  endtask

  // One clock: sample at the falling edge, return just after the rising edge
  task automatic step();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      s_cfg_ready[d] = cfg_ready[d];
      s_act_ready[d] = act_ready[d];
      s_act_en[d]    = act_en[d];
      s_w_en[d]      = w_en[d];
      s_w_addr[d]    = w_addr[d];
      s_th_en[d]     = th_en[d];
      s_th_addr[d]   = th_addr[d];
      s_fold[d]      = fold_add[d];
      s_mp[d]        = mp_en[d];
      s_ov[d]        = out_valid[d];
      s_row[d]       = out_row[d];
      s_col[d]       = out_col[d];
      s_busy[d]      = busy[d];
      s_done[d]      = done[d];
      mon(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic run_stream();
    int n;
    n = 0;
    while ((done_cnt[0] == 0 || done_cnt[1] == 0) && n < 300) begin
      step();
      n++;
    end
    chk("run_completed", 0, int'(done_cnt[0] != 0 && done_cnt[1] != 0), 1);
    act_valid = 1'b0;
    step();
    step();
    chk("pooled_out_count", 0, out_cnt[0], 2);
    chk("raw_out_count", 1, out_cnt[1], NPIX);
    for (int d = 0; d < 2; d++) begin
      chk("done_count", d, done_cnt[d], 1);
      chk("idle_after_run", d, int'(s_busy[d]), 0);
    end
    chk("pending_tags", 0, q0.size(), 0);
    chk("pending_tags", 1, q1.size(), 0);
  endtask

  initial begin
    int n;
    reset     = 1'b1;
    start     = 1'b0;
    cfg_load  = 1'b0;
    cfg_valid = 1'b0;
    act_valid = 1'b0;
    steady    = 1'b0;
    clear_model();

    // Reset state
    step();
    step();
    for (int d = 0; d < 2; d++) begin
      chk("reset_busy", d, int'(s_busy[d]), 0);
      chk("reset_strobes", d, int'({s_cfg_ready[d], s_act_ready[d], s_w_en[d], s_th_en[d],
                                     s_ov[d], s_done[d], s_mp[d]}), 0);
    end
    reset = 1'b0;
    step();

    // Run 1: stalled config load, ignored start in ACT, steady stream
    start    = 1'b1;
    cfg_load = 1'b1;
    step();
    chk("idle_cfg_ready", 0, int'(s_cfg_ready[0]), 0);
    start     = 1'b0;
    cfg_load  = 1'b0;
    cfg_valid = 1'b1;
    step();
    for (int d = 0; d < 2; d++) begin
      chk("w0_en", d, int'(s_w_en[d]), 1);
      chk("w0_addr", d, int'(s_w_addr[d]), 0);
      chk("w0_th_en", d, int'(s_th_en[d]), 0);
    end
    cfg_valid = 1'b0;
    step();
    chk("w_stall_en", 0, int'(s_w_en[0]), 0);
    chk("w_stall_ready", 0, int'(s_cfg_ready[0]), 1);
    cfg_valid = 1'b1;
    step();
    chk("w1_en", 0, int'(s_w_en[0]), 1);
    chk("w1_addr", 0, int'(s_w_addr[0]), 1);
    cfg_valid = 1'b0;
    step();
    chk("th_stall_en", 0, int'({s_w_en[0], s_th_en[0]}), 0);
    chk("th_stall_ready", 0, int'(s_cfg_ready[0]), 1);
    cfg_valid = 1'b1;
    step();
    chk("th0_en", 0, int'(s_th_en[0]), 1);
    chk("th0_addr", 0, int'(s_th_addr[0]), 0);
    chk("th0_w_en", 0, int'(s_w_en[0]), 0);
    step();
    chk("th1_en", 0, int'(s_th_en[0]), 1);
    chk("th1_addr", 0, int'(s_th_addr[0]), 1);
    cfg_valid = 1'b0;
    start     = 1'b1;
    cfg_load  = 1'b1;
    step();
    chk("act_ready_after_cfg", 0, int'(s_act_ready[0]), 1);
    chk("act_cfg_ready", 0, int'(s_cfg_ready[0]), 0);
    chk("act_no_accept", 0, int'(s_act_en[0]), 0);
    start    = 1'b0;
    cfg_load = 1'b0;
    step();
    chk("start_ignored_act", 0, int'(s_act_ready[0]), 1);
    chk("start_ignored_busy", 1, int'(s_busy[1]), 1);
    steady    = 1'b1;
    act_valid = 1'b1;
    run_stream();

    // Run 2: asynchronous reset in the middle of FOLD
    clear_model();
    start = 1'b1;
    step();
    start     = 1'b0;
    act_valid = 1'b1;
    n = 0;
    while (!(px[0] == 3 && cyc == last_hs[0] + 2) && n < 60) begin
      step();
      n++;
    end
    chk("reached_third_pixel", 0, px[0], 3);
    chk("pre_reset_fold_add", 0, int'(fold_add[0]), 1);
    #2;
    reset = 1'b1;
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("async_reset_ctrl", d, int'({cfg_ready[d], act_ready[d], act_en[d], w_en[d], w_addr[d],
                                        th_en[d], th_addr[d], fold_add[d], mp_en[d],
                                        out_valid[d], busy[d], done[d]}), 0);
      chk("async_reset_coord", d, int'({out_row[d], out_col[d]}), 0);
    end
    clear_model();
    act_valid = 1'b0;
    step();
    reset = 1'b0;
    step();
    chk("post_reset_busy", 0, int'(s_busy[0]), 0);

    // Run 3: config with cfg_valid held high, restart from pixel (0,0)
    start     = 1'b1;
    cfg_load  = 1'b1;
    cfg_valid = 1'b1;
    step();
    chk("idle_ignores_cfg", 0, int'(s_w_en[0]), 0);
    start    = 1'b0;
    cfg_load = 1'b0;
    step();
    chk("hold_w0", 0, int'({s_w_en[0], s_w_addr[0]}), 2);
    step();
    chk("hold_w1", 0, int'({s_w_en[0], s_w_addr[0]}), 3);
    step();
    chk("hold_th0", 0, int'({s_th_en[0], s_th_addr[0], s_w_en[0]}), 4);
    step();
    chk("hold_th1", 0, int'({s_th_en[0], s_th_addr[0], s_w_en[0]}), 6);
    step();
    for (int d = 0; d < 2; d++) begin
      chk("hold_act_ready", d, int'(s_act_ready[d]), 1);
      chk("hold_cfg_ready", d, int'(s_cfg_ready[d]), 0);
      chk("hold_th_done", d, int'(s_th_en[d]), 0);
    end
    cfg_valid = 1'b0;
    act_valid = 1'b1;
    run_stream();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_layer_sequencer.md
# conv_layer_sequencer

Control FSM that sequences one folded binary convolution layer. It loads per-fold weight and threshold words into the layer's memory blocks and admits input activation pixels through a valid/ready handshake. For each pixel it steps `fold_add` through every output-channel fold, pulses the max-pool enable, and flags which output words are valid. It sits between the upstream activation/config streams and the convolution datapath, which receives data buses directly while this block drives every enable and address.

## Interface
Parameters:
- `fold`, 2: output-channel folds per pixel; must be ≥2.
- `fold_log`, `$clog2(fold)`: width of all fold addresses.
- `w_in`, 32: feature-map width in pixels.
- `h_in`, 32: feature-map height in pixels.
- `MAXPOOL_enable`, 1: 1 means outputs are pooled; 0 means raw thresholded outputs.
- `k_s_maxpool`, 2: pooling window side.
- `out_lat`, 2: cycles from the pool-enable pulse to a valid pooled word at the layer output.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  single-cycle pulse that begins a layer run; ignored unless the FSM is in IDLE.
- `cfg_load`  in  1  sampled with `start`; 1 loads weights and thresholds before the run.
- `cfg_valid`  in  1  upstream config word present.
- `cfg_ready`  out  1  config word accepted this cycle when `cfg_valid` is also high.
- `act_valid`  in  1  upstream activation pixel present.
- `act_ready`  out  1  pixel accepted this cycle when `act_valid` is also high.
- `stream_act_en`  out  1  shifts the pixel into the input buffer; equals `act_valid & act_ready`.
- `stream_w_en`  out  1  weight-word write strobe.
- `stream_w_addr`  out  `fold_log`  weight fold address.
- `stream_th_en`  out  1  threshold-word write strobe.
- `stream_th_addr`  out  `fold_log`  threshold fold address.
- `fold_add`  out  `fold_log`  fold currently computed by the processing elements.
- `stream_maxpool_en`  out  1  max-pool shift strobe.
- `out_valid`  out  1  the layer output word is valid this cycle.
- `out_row`  out  16  output-map row of the valid word.
- `out_col`  out  16  output-map column of the valid word.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at the end of a run.

## Operation
States: IDLE, LOAD_W, LOAD_TH, ACT, FOLD, POOL, DRAIN.

**IDLE**
- `start` with `cfg_load`=1 → LOAD_W.
- `start` with `cfg_load`=0 → ACT.
- Pixel counters clear to 0 on leaving IDLE.

**LOAD_W**
- `cfg_ready`=1.
- On each handshake: `stream_w_en`=1 and `stream_w_addr`=wcnt; wcnt then increments.
- After the handshake with wcnt=`fold`-1 → LOAD_TH, and wcnt clears.

**LOAD_TH**
- Same behaviour using `stream_th_en` and `stream_th_addr`.
- After `fold` accepted words → ACT.

**ACT**
- `act_ready`=1.
- On a handshake → FOLD, with fcnt=0.
- No handshake → remain in ACT.

**FOLD**
- Lasts exactly `fold` cycles, with `fold_add`=fcnt=0..`fold`-1.
- Then → POOL.

**POOL**
- One cycle; `stream_maxpool_en` = `MAXPOOL_enable`.
- Advance col; at `w_in`-1, col wraps to 0 and row increments.
- Last pixel (row=`h_in`-1, col=`w_in`-1) → DRAIN; otherwise → ACT.

**DRAIN**
- Waits until the output-delay pipeline is empty.
- Then pulses `done` → IDLE.

**Output tagging**
- Each POOL cycle pushes a tag {valid, row, col} into a delay line: `out_lat` stages when `MAXPOOL_enable`=1, 0 stages otherwise.
- The tag is valid iff `MAXPOOL_enable`=0, or (row mod `k_s_maxpool`=`k_s_maxpool`-1 and col mod `k_s_maxpool`=`k_s_maxpool`-1).
- Pooled coordinates are row/`k_s_maxpool` and col/`k_s_maxpool`; unpooled coordinates are row and col unchanged.
- The delay line runs independently of the FSM, so tags overlap with the next pixel.

**Boundary and reset behaviour**
- Outside the owning state, every strobe, ready, `fold_add`, and address is 0.
- `start` outside IDLE is ignored.
- `cfg_valid` and `act_valid` are ignored in states where the matching ready is 0.
- Asynchronous `reset` at any time, including mid-run:
  - FSM → IDLE.
  - All counters cleared.
  - Delay line cleared.
  - All outputs 0.
- Counter widths: col and row counters are 16 bits.

## Timing
- Pixel accepted at edge t (FSM in ACT).
  - `fold_add`=k during cycle t+1+k.
  - POOL occupies cycle t+`fold`+1.
  - ACT is re-entered at t+`fold`+2.
- Pixel period is `fold`+2 cycles; any upstream stall adds cycles in ACT.
- `out_valid` for that pixel:
  - Cycle t+`fold`+1+`out_lat` when `MAXPOOL_enable`=1.
  - Cycle t+`fold`+1 when `MAXPOOL_enable`=0.
- Config load takes 2·`fold` handshake cycles minimum; no bubble between LOAD_W and LOAD_TH.
- `done` is asserted in the cycle after the last tag leaves the delay line.

## Test plan
- **Reset**: assert `reset` asynchronously mid-FOLD (`fold`=2) → all outputs 0 in the same cycle; `busy`=0; the next `start` restarts from pixel (0,0).
- **Config load**: `start`, `cfg_load`=1, `cfg_valid` held high →
  - `stream_w_en` with addr 0,1 on consecutive cycles;
  - then `stream_th_en` with addr 0,1;
  - then `act_ready`=1.
- **Stalled config**: toggle `cfg_valid` 1,0,1,0 in LOAD_W → `stream_w_en` pulses only on the handshake cycles, and addresses still increment 0→1.
- **Steady stream** (`w_in`=4, `h_in`=2, `fold`=2, pooling 2×2, `out_lat`=2), `act_valid` held high →
  - `fold_add` sequence 0,1 per pixel, with `stream_maxpool_en` every 4th cycle;
  - `out_valid` exactly twice, at (0,0) and (0,1), each 2 cycles after the POOL cycles of pixels (1,1) and (1,3);
  - `done` once.
- **Unpooled** (`MAXPOOL_enable`=0) → `out_valid` in every POOL cycle, 8 pulses total, coordinates equal to the pixel coordinates, `stream_maxpool_en` never asserted.
- **Ignored inputs**: `start` asserted during ACT and `act_valid` asserted during FOLD → no state change, `stream_act_en` stays 0, and pixel count is unaffected.
